// File: rtl/div_sched_pkg.sv
// Shared definitions for the divider scheduler: FSM encoding, result-field
// slice positions and the divide-by-zero / signed-overflow bypass constants.
package div_sched_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // div_result packs {remainder, quotient}
    localparam int REM_MSB = 63;
    localparam int REM_LSB = 32;
    localparam int QUO_MSB = 31;
    localparam int QUO_LSB = 0;

    localparam logic [DATA_W-1:0] DIV0_QUO = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] OVF_A    = 32'h8000_0000;
    localparam logic [DATA_W-1:0] OVF_B    = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] OVF_QUO  = 32'h8000_0000;
    localparam logic [DATA_W-1:0] OVF_REM  = 32'h0000_0000;

    function automatic logic is_ovf(input logic sgn, input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
        return sgn && (a == OVF_A) && (b == OVF_B);
    endfunction

endpackage

// File: rtl/div_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer names the requester favoured when
// both are valid and flips to the other side on every accepted grant.
module div_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one iterative divider between two requesters, with zero-divisor and
// signed-overflow bypass. Define DIV_SCHEDULER_CACHE_EN for a one-entry result cache.
module div_scheduler
    import div_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_signed,
    input  logic                req0_rem,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    input  logic                req0_flush,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_signed,
    input  logic                req1_rem,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    input  logic                req1_flush,

    output logic                resp0_valid,
    output logic [DATA_W-1:0]   resp0_data,
    output logic                resp1_valid,
    output logic [DATA_W-1:0]   resp1_data,

    output logic                div_start,
    output logic                div_annul,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_a,
    output logic [DATA_W-1:0]   div_b,
    input  logic [2*DATA_W-1:0] div_result,
    input  logic                div_ready
);

    state_t              state, state_nxt;
    logic [1:0]          gnt;
    logic                idle_ok;
    logic                accept;
    logic                win;
    logic                sel_sgn;
    logic                sel_rem;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    logic                own_q;
    logic                rem_q;
    logic [2*DATA_W-1:0] res_q;
    logic                own_flush;
    logic                capture;

    logic                fast_hit;
    logic [2*DATA_W-1:0] fast_res;
    logic                cache_hit;
    logic [2*DATA_W-1:0] cache_res;

    logic                resp_fire;
    logic [DATA_W-1:0]   resp_field;

    div_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    // Ready is only offered while idle, and never while reset is held
    assign idle_ok    = (state == IDLE) && !rst;
    assign req0_ready = idle_ok && gnt[0];
    assign req1_ready = idle_ok && gnt[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign win     = gnt[1];
    assign sel_sgn = win ? req1_signed : req0_signed;
    assign sel_rem = win ? req1_rem    : req0_rem;
    assign sel_a   = win ? req1_a      : req0_a;
    assign sel_b   = win ? req1_b      : req0_b;

    assign own_flush = own_q ? req1_flush : req0_flush;
    assign capture   = (state == BUSY) && !own_flush && div_ready;

    always_comb begin
        fast_hit = 1'b1;
        fast_res = '0;
        if (sel_b == '0) begin
            fast_res = {sel_a, DIV0_QUO};
        end else if (is_ovf(sel_sgn, sel_a, sel_b)) begin
            fast_res = {OVF_REM, OVF_QUO};
        end else if (cache_hit) begin
            fast_res = cache_res;
        end else begin
            fast_hit = 1'b0;
        end
    end

`ifdef DIV_SCHEDULER_CACHE_EN
    logic                c_vld;
    logic                c_sgn;
    logic [DATA_W-1:0]   c_a;
    logic [DATA_W-1:0]   c_b;
    logic [2*DATA_W-1:0] c_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_vld <= 1'b0;
        end else if (capture) begin
            c_vld <= 1'b1;
        end
    end

    // Operands are read from the held divider inputs at capture time
    always_ff @(posedge clk) begin
        if (capture) begin
            c_sgn <= div_signed;
            c_a   <= div_a;
            c_b   <= div_b;
            c_res <= div_result;
        end
    end

    assign cache_hit = c_vld && (c_sgn == sel_sgn) && (c_a == sel_a) && (c_b == sel_b);
    assign cache_res = c_res;
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = fast_hit ? DONE : BUSY;
                end
            end
            BUSY: begin
                // A flush wins over a simultaneous divider completion
                if (own_flush) begin
                    state_nxt = IDLE;
                end else if (div_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = div_ready ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!div_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q      <= 1'b0;
            rem_q      <= 1'b0;
            res_q      <= '0;
            div_signed <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            div_annul  <= 1'b0;
        end else begin
            div_annul <= (state == BUSY) && own_flush;
            if (accept) begin
                own_q      <= win;
                rem_q      <= sel_rem;
                div_signed <= sel_sgn;
                div_a      <= sel_a;
                div_b      <= sel_b;
                if (fast_hit) begin
                    res_q <= fast_res;
                end
            end else if (capture) begin
                res_q <= div_result;
            end
        end
    end

    assign div_start = (state == BUSY);

    // Response strobe lives for the single DONE cycle; data is zero otherwise
    assign resp_fire  = (state == DONE) && !own_flush;
    assign resp_field = rem_q ? res_q[REM_MSB:REM_LSB] : res_q[QUO_MSB:QUO_LSB];

    assign resp0_valid = resp_fire && !own_q;
    assign resp1_valid = resp_fire &&  own_q;
    assign resp0_data  = resp0_valid ? resp_field : '0;
    assign resp1_data  = resp1_valid ? resp_field : '0;

endmodule

// File: tb/tb_div_scheduler.sv
// Randomized bench for div_scheduler with a behavioural divider and a
// request-level reference model (arbitration, bypass, optional cache).
module tb_div_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_signed, req0_rem, req0_flush;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_signed, req1_rem, req1_flush;
    logic [31:0] req1_a, req1_b;
    logic        resp0_valid, resp1_valid;
    logic [31:0] resp0_data, resp1_data;
    logic        div_start, div_annul, div_signed, div_ready;
    logic [31:0] div_a, div_b;
    logic [63:0] div_result;

    always #5 clk = ~clk;

    div_scheduler dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_signed(req0_signed),
        .req0_rem(req0_rem), .req0_a(req0_a), .req0_b(req0_b), .req0_flush(req0_flush),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_signed(req1_signed),
        .req1_rem(req1_rem), .req1_a(req1_a), .req1_b(req1_b), .req1_flush(req1_flush),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
        .div_a(div_a), .div_b(div_b), .div_result(div_result), .div_ready(div_ready)
    );

    typedef struct packed {
        logic        sgn;
        logic        rem;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural result {remainder, quotient} for one division
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    // Reference-model state
    int   rr_last = 1;
    bit   mc_vld  = 0;
    req_t mc_req;

    // Behavioural divider
    int   lat_cfg = 0;
    int   dcnt = 0, dlat = 1, dhold = 0;
    int   n_start = 0;
    logic start_prev = 1'b0;

    initial begin
        div_ready  = 1'b0;
        div_result = 64'd0;
        forever begin
            @(negedge clk);
            if (rst || div_annul) begin
                div_ready = 1'b0;
                dcnt      = 0;
            end else if (div_start && !div_ready) begin
                if (dcnt == 0) dlat = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
                dcnt++;
                if (dcnt >= dlat) begin
                    div_ready  = 1'b1;
                    div_result = ref_div(div_signed, div_a, div_b);
                    dhold      = int'($urandom_range(0, 2));
                    dcnt       = 0;
                end
            end else if (div_ready && !div_start) begin
                if (dhold > 0) dhold--;
                else div_ready = 1'b0;
            end
            if (div_start && !start_prev) n_start++;
            start_prev = div_start;
        end
    end

    // Response monitor and per-cycle exclusivity rules
    int          n_resp0 = 0, n_resp1 = 0;
    logic [31:0] last0 = 32'd0, last1 = 32'd0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("resp_exclusive", 64'(resp0_valid & resp1_valid), 64'd0);
                check("start_annul_exclusive", 64'(div_start & div_annul), 64'd0);
                if (resp0_valid) begin n_resp0++; last0 = resp0_data; end
                if (resp1_valid) begin n_resp1++; last1 = resp1_data; end
            end
        end
    end

    // mode: 0 normal, 1 owner flush in BUSY, 2 owner flush in DONE,
    //       3 non-owner flush, 4 owner flush coinciding with div_ready
    task automatic issue(input bit v0, input bit v1, input req_t t0, input req_t t1,
                         input int mode_in);
        int          w, exp_w, c0, c1, s0, cnt, mode;
        bit          got, exp_busy, hit;
        req_t        t;
        logic [63:0] exp_res;
        logic [31:0] exp_data;
        mode = mode_in;
        @(negedge clk);
        req0_valid = v0; req0_signed = t0.sgn; req0_rem = t0.rem; req0_a = t0.a; req0_b = t0.b;
        req1_valid = v1; req1_signed = t1.sgn; req1_rem = t1.rem; req1_a = t1.a; req1_b = t1.b;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (req0_ready || req1_ready) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            check("accept_timeout", 64'd0, 64'd1);
            req0_valid = 0; req1_valid = 0;
            return;
        end
        w     = req1_ready ? 1 : 0;
        exp_w = (v0 && v1) ? (1 - rr_last) : (v1 ? 1 : 0);
        check("grant", 64'(w), 64'(exp_w));
        check("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
        rr_last = w;
        t = w ? t1 : t0;
        hit = 0;
`ifdef DIV_SCHEDULER_CACHE_EN
        hit = mc_vld && mc_req.sgn == t.sgn && mc_req.a == t.a && mc_req.b == t.b;
`endif
        exp_busy = !(t.b == 0 || (t.sgn && t.a == 32'h8000_0000 && t.b == 32'hFFFF_FFFF)) && !hit;
        exp_res  = ref_div(t.sgn, t.a, t.b);
        exp_data = t.rem ? exp_res[63:32] : exp_res[31:0];
        if ((mode == 1 || mode == 4) && !exp_busy) mode = 0;
        if (mode == 2 && exp_busy) mode = 0;
        lat_cfg = (mode == 1) ? 8 : (mode == 4) ? 3 : 0;
        c0 = n_resp0; c1 = n_resp1; s0 = n_start;
        @(posedge clk);
        #1;
        req0_valid = 0; req1_valid = 0;
        if (mode == 1 || mode == 4) begin
            cnt = 0;
            for (int i = 0; i < 20 && cnt < 3; i++) begin
                @(negedge clk);
                #1;
                if (div_start) cnt++;
            end
            if (w == 1) req1_flush = 1; else req0_flush = 1;
            @(negedge clk);
            req0_flush = 0; req1_flush = 0;
            #2;
            check("annul_pulse", 64'(div_annul), 64'd1);
            check("start_after_flush", 64'(div_start), 64'd0);
            @(negedge clk);
            #2;
            check("annul_one_cycle", 64'(div_annul), 64'd0);
            repeat (6) @(negedge clk);
            #3;
            check("flush_no_resp", 64'((n_resp0 - c0) + (n_resp1 - c1)), 64'd0);
        end else if (mode == 2) begin
            if (w == 1) req1_flush = 1; else req0_flush = 1;
            @(negedge clk);
            #3;
            req0_flush = 0; req1_flush = 0;
            repeat (3) @(negedge clk);
            #3;
            check("done_flush_no_resp", 64'((n_resp0 - c0) + (n_resp1 - c1)), 64'd0);
            check("done_flush_starts", 64'(n_start - s0), 64'd0);
        end else begin
            if (mode == 3) begin
                if (w == 1) req0_flush = 1; else req1_flush = 1;
            end
            for (int i = 0; i < 40 && (n_resp0 + n_resp1) == (c0 + c1); i++) begin
                @(negedge clk);
                #3;
            end
            req0_flush = 0; req1_flush = 0;
            repeat (3) @(negedge clk);
            #3;
            check("resp_own",   64'(w ? n_resp1 - c1 : n_resp0 - c0), 64'd1);
            check("resp_other", 64'(w ? n_resp0 - c0 : n_resp1 - c1), 64'd0);
            check("resp_data",  64'(w ? last1 : last0), 64'(exp_data));
            check("div_starts", 64'(n_start - s0), 64'(exp_busy));
            if (exp_busy) begin
                mc_vld = 1;
                mc_req = t;
            end
        end
        lat_cfg = 0;
    endtask

    task automatic reset_mid_busy();
        int c0, c1;
        req_t t;
        t = '{sgn: 1'b0, rem: 1'b0, a: 32'd1000, b: 32'd3};
        issue_start_only(t);
        repeat (2) @(negedge clk);
        req0_valid = 1;
        #3;
        rst = 1;
        #1;
        check("rst_div_start",  64'(div_start), 64'd0);
        check("rst_div_annul",  64'(div_annul), 64'd0);
        check("rst_div_a",      64'(div_a), 64'd0);
        check("rst_div_b",      64'(div_b), 64'd0);
        check("rst_div_signed", 64'(div_signed), 64'd0);
        check("rst_ready",      64'({req0_ready, req1_ready}), 64'd0);
        check("rst_resp",       64'({resp0_valid, resp1_valid, resp0_data, resp1_data}), 64'd0);
        req0_valid = 0;
        rr_last = 1;
        mc_vld  = 0;
        lat_cfg = 0;
        c0 = n_resp0; c1 = n_resp1;
        @(negedge clk);
        #3;
        rst = 0;
        repeat (10) @(negedge clk);
        #3;
        check("rst_no_resp", 64'((n_resp0 - c0) + (n_resp1 - c1)), 64'd0);
    endtask

    // Launches a long-latency request on requester 0 and returns once it is in BUSY
    task automatic issue_start_only(input req_t t);
        bit got;
        lat_cfg = 10;
        @(negedge clk);
        req0_valid = 1; req0_signed = t.sgn; req0_rem = t.rem; req0_a = t.a; req0_b = t.b;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (req0_ready) got = 1;
            else @(negedge clk);
        end
        check("rst_setup_accept", 64'(got), 64'd1);
        rr_last = 0;
        @(posedge clk);
        #1;
        req0_valid = 0;
        @(negedge clk);
        #1;
        check("rst_setup_busy", 64'(div_start), 64'd1);
    endtask

    function automatic req_t mk(input logic sgn, input logic rem, input logic [31:0] a,
                                input logic [31:0] b);
        req_t r;
        r.sgn = sgn; r.rem = rem; r.a = a; r.b = b;
        return r;
    endfunction

    function automatic req_t rand_req(input req_t prev);
        req_t r;
        int   k;
        k     = int'($urandom_range(0, 99));
        r.sgn = 1'($urandom_range(0, 1));
        r.rem = 1'($urandom_range(0, 1));
        r.a   = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 1000);
        r.b   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 50) : $urandom;
        if (k < 10) r.b = 32'd0;
        else if (k < 15) begin r.sgn = 1; r.a = 32'h8000_0000; r.b = 32'hFFFF_FFFF; end
        else if (k < 30) begin r.sgn = prev.sgn; r.a = prev.a; r.b = prev.b; end
        return r;
    endfunction

    req_t nul;
    req_t p0, p1;
    int   mode, sel;

    initial begin
        nul = '0;
        req0_valid = 0; req0_signed = 0; req0_rem = 0; req0_a = 0; req0_b = 0; req0_flush = 0;
        req1_valid = 0; req1_signed = 0; req1_rem = 0; req1_a = 0; req1_b = 0; req1_flush = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_div_start", 64'(div_start), 64'd0);
        check("reset_resp", 64'({resp0_valid, resp1_valid, resp0_data, resp1_data}), 64'd0);
        check("reset_div_ops", 64'({div_signed, div_annul, div_a, div_b}), 64'd0);
        #2;
        rst = 0;

        issue(1, 0, mk(0, 0, 32'd100, 32'd7), nul, 0);
        issue(1, 0, mk(0, 1, 32'd100, 32'd7), nul, 0);
        issue(0, 1, nul, mk(1, 0, -32'sd7, 32'd0), 0);
        issue(0, 1, nul, mk(1, 0, 32'h8000_0000, 32'hFFFF_FFFF), 0);
        issue(1, 1, mk(0, 0, 32'd50, 32'd5), mk(0, 1, 32'd50, 32'd6), 0);
        issue(1, 1, mk(0, 0, 32'd81, 32'd9), mk(0, 0, 32'd77, 32'd7), 0);
        issue(1, 0, mk(0, 0, 32'd1000, 32'd3), nul, 1);
        issue(1, 0, mk(0, 0, 32'd9, 32'd3), nul, 0);
        issue(0, 1, nul, mk(0, 0, 32'd500, 32'd7), 4);
        issue(1, 0, mk(1, 0, -32'sd20, 32'd6), nul, 0);
        issue(1, 0, mk(1, 0, -32'sd20, 32'd6), nul, 0);
        issue(1, 0, mk(1, 1, -32'sd20, 32'd6), nul, 0);
        issue(0, 1, nul, mk(0, 0, 32'd5, 32'd0), 2);
        issue(1, 0, mk(0, 1, 32'd123, 32'd10), nul, 3);

        p0 = nul; p1 = nul;
        for (int i = 0; i < 150; i++) begin
            p0  = rand_req(p1);
            p1  = rand_req(p0);
            sel = int'($urandom_range(0, 2));
            mode = int'($urandom_range(0, 9));
            mode = (mode < 6) ? 0 : (mode == 6) ? 1 : (mode == 7) ? 2 : (mode == 8) ? 3 : 4;
            issue(sel != 1, sel != 0, p0, p1, mode);
        end

        reset_mid_busy();
        issue(1, 1, mk(0, 0, 32'd64, 32'd8), mk(0, 0, 32'd60, 32'd4), 0);
        issue(0, 1, nul, mk(1, 1, -32'sd17, 32'd5), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
